// File: rtl/player_ctrl.sv
// Ship sprite controller: per accepted frame tick, optionally erase, issue one vertical move pulse, redraw.
// Outputs are registered and reflect the current state/pixel index; frame ticks are ignored while busy.
module player_ctrl #(
  parameter int         MOVE_DIV    = 2,
  parameter int         Y_MAX       = 116,
  parameter logic [2:0] SHIP_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       add_x,
  output logic [1:0] add_y,
  output logic       y_pos_mod,
  output logic       y_neg_mod,
  output logic       plot,
  output logic [2:0] colour,
  output logic       busy,
  output logic       done
);

  localparam int DW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int YW = $clog2(Y_MAX + 1);

  typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, DONE} state_t;

  state_t          state;
  logic [2:0]      idx;
  logic [2:0]      idx_next;
  logic [DW-1:0]   divider;
  logic [YW-1:0]   shadow_y;
  logic            dir_down;
  logic            div_hit;
  logic            want_down;
  logic            want_up;

  assign idx_next  = idx + 3'd1;
  assign div_hit   = (divider == DW'(MOVE_DIV - 1));
  assign want_down = btn_down & ~btn_up & (shadow_y < YW'(Y_MAX)) & div_hit;
  assign want_up   = btn_up & ~btn_down & (shadow_y != '0) & div_hit;
  assign busy      = (state != IDLE);

  // Outputs are loaded on the same edge as the state they describe, so the
  // offsets, plot and colour always line up with the datapath's x/y mapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      divider   <= '0;
      shadow_y  <= '0;
      dir_down  <= 1'b0;
      add_x     <= 1'b0;
      add_y     <= 2'd0;
      y_pos_mod <= 1'b0;
      y_neg_mod <= 1'b0;
      plot      <= 1'b0;
      colour    <= 3'd0;
      done      <= 1'b0;
    end else begin
      add_x     <= 1'b0;
      add_y     <= 2'd0;
      y_pos_mod <= 1'b0;
      y_neg_mod <= 1'b0;
      plot      <= 1'b0;
      colour    <= 3'd0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            divider <= div_hit ? '0 : divider + DW'(1);
            idx     <= 3'd0;
            plot    <= 1'b1;
            if (want_down || want_up) begin
              dir_down <= want_down;
              state    <= ERASE;
            end else begin
              colour <= SHIP_COLOUR;
              state  <= DRAW;
            end
          end
        end
        ERASE: begin
          if (idx == 3'd7) begin
            idx       <= 3'd0;
            y_pos_mod <= dir_down;
            y_neg_mod <= ~dir_down;
            state     <= MOVE;
          end else begin
            idx   <= idx_next;
            plot  <= 1'b1;
            add_x <= idx_next[0];
            add_y <= idx_next[2:1];
          end
        end
        MOVE: begin
          // Track the datapath's base y on the edge that consumes the pulse.
          shadow_y <= dir_down ? shadow_y + YW'(1) : shadow_y - YW'(1);
          idx      <= 3'd0;
          plot     <= 1'b1;
          colour   <= SHIP_COLOUR;
          state    <= DRAW;
        end
        DRAW: begin
          if (idx == 3'd7) begin
            idx   <= 3'd0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx    <= idx_next;
            plot   <= 1'b1;
            colour <= SHIP_COLOUR;
            add_x  <= idx_next[0];
            add_y  <= idx_next[2:1];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: two instances (move every frame, move every second frame).
// Frame-level vector table plus hand sequences for bounds, re-tick and mid-sequence reset.
module tb_player_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       tick1 = 1'b0, up1 = 1'b0, dn1 = 1'b0;
  logic       tick2 = 1'b0, up2 = 1'b0, dn2 = 1'b0;
  logic       ax1, ax2, ypm1, ypm2, ynm1, ynm2, plot1, plot2, busy1, busy2, done1, done2;
  logic [1:0] ay1, ay2;
  logic [2:0] col1, col2;

  player_ctrl #(.MOVE_DIV(1), .Y_MAX(116), .SHIP_COLOUR(3'b010)) u1 (
    .clk(clk), .reset_n(reset_n), .frame_tick(tick1), .btn_up(up1), .btn_down(dn1),
    .add_x(ax1), .add_y(ay1), .y_pos_mod(ypm1), .y_neg_mod(ynm1),
    .plot(plot1), .colour(col1), .busy(busy1), .done(done1)
  );

  player_ctrl #(.MOVE_DIV(2), .Y_MAX(116), .SHIP_COLOUR(3'b010)) u2 (
    .clk(clk), .reset_n(reset_n), .frame_tick(tick2), .btn_up(up2), .btn_down(dn2),
    .add_x(ax2), .add_y(ay2), .y_pos_mod(ypm2), .y_neg_mod(ynm2),
    .plot(plot2), .colour(col2), .busy(busy2), .done(done2)
  );

  int total = 0;
  int bad = 0;

  // kind: 0 = no move (draw only), 1 = move down, 2 = move up
  typedef struct {
    int   d;
    logic up;
    logic dn;
    int   retick;
    int   rst_at;
    int   kind;
    int   y;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [10:0] act_vec(input int d);
    if (d == 0) return {plot1, col1, ax1, ay1, ypm1, ynm1, busy1, done1};
    return {plot2, col2, ax2, ay2, ypm2, ynm2, busy2, done2};
  endfunction

  // {plot, colour, add_x, add_y, y_pos_mod, y_neg_mod, busy, done} for cycle c after the tick
  function automatic logic [10:0] exp_vec(input int kind, input int c);
    logic       pl = 1'b0, ax = 1'b0, p = 1'b0, n = 1'b0, b = 1'b0, dn = 1'b0;
    logic [2:0] col = 3'd0;
    logic [1:0] ay = 2'd0;
    logic [2:0] idx = 3'd0;
    if (kind == 0) begin
      if (c <= 8) begin
        pl = 1'b1; col = 3'b010; idx = 3'(c - 1); b = 1'b1;
      end else if (c == 9) begin
        dn = 1'b1; b = 1'b1;
      end
    end else begin
      if (c <= 8) begin
        pl = 1'b1; col = 3'b000; idx = 3'(c - 1); b = 1'b1;
      end else if (c == 9) begin
        p = (kind == 1); n = (kind == 2); b = 1'b1;
      end else if (c <= 17) begin
        pl = 1'b1; col = 3'b010; idx = 3'(c - 10); b = 1'b1;
      end else if (c == 18) begin
        dn = 1'b1; b = 1'b1;
      end
    end
    if (pl) begin
      ax = idx[0];
      ay = idx[2:1];
    end
    return {pl, col, ax, ay, p, n, b, dn};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int d, input logic t, input logic u, input logic n);
    if (d == 0) begin tick1 = t; up1 = u; dn1 = n; end
    else        begin tick2 = t; up2 = u; dn2 = n; end
  endtask

  task automatic run_frame(input int d, input logic u, input logic n,
                           input int retick, input int rst_at, input int kind);
    int len = (kind == 0) ? 10 : 19;
    @(negedge clk);
    set_in(d, 1'b1, u, n);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      set_in(d, (c == retick) ? 1'b1 : 1'b0, u, n);
      check($sformatf("dut%0d kind%0d cycle%0d", d + 1, kind, c), int'(act_vec(d)), int'(exp_vec(kind, c)));
      if (c == rst_at) begin
        reset_n = 1'b0;
        #1;
        check("reset mid-frame dut1", int'(act_vec(0)), 0);
        check("reset mid-frame dut2", int'(act_vec(1)), 0);
        @(negedge clk);
        reset_n = 1'b1;
        break;
      end
    end
    set_in(d, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic int shadow(input int d);
    return (d == 0) ? int'(u1.shadow_y) : int'(u2.shadow_y);
  endfunction

  initial begin
    //          d  up    dn    retick rst kind y
    tbl[0]  = '{0, 1'b0, 1'b0, 0, 0,  0,  0};
    tbl[1]  = '{0, 1'b0, 1'b1, 0, 0,  1,  1};
    tbl[2]  = '{0, 1'b1, 1'b0, 0, 0,  2,  0};
    tbl[3]  = '{0, 1'b1, 1'b0, 0, 0,  0,  0};
    tbl[4]  = '{0, 1'b1, 1'b1, 0, 0,  0,  0};
    tbl[5]  = '{1, 1'b0, 1'b1, 0, 0,  0,  0};
    tbl[6]  = '{1, 1'b0, 1'b1, 0, 0,  1,  1};
    tbl[7]  = '{1, 1'b0, 1'b1, 0, 0,  0,  1};
    tbl[8]  = '{1, 1'b0, 1'b1, 0, 0,  1,  2};
    tbl[9]  = '{1, 1'b1, 1'b1, 0, 0,  0,  2};
    tbl[10] = '{1, 1'b1, 1'b1, 0, 0,  0,  2};
    tbl[11] = '{1, 1'b0, 1'b0, 0, 0,  0,  2};
    tbl[12] = '{1, 1'b0, 1'b1, 5, 0,  1,  3};
    tbl[13] = '{1, 1'b0, 1'b1, 0, 0,  0,  3};
    tbl[14] = '{1, 1'b0, 1'b1, 0, 12, 1,  0};
    tbl[15] = '{1, 1'b1, 1'b0, 0, 0,  0,  0};
    tbl[16] = '{1, 1'b0, 1'b1, 0, 0,  1,  1};

    #1;
    check("reset outputs dut1", int'(act_vec(0)), 0);
    check("reset outputs dut2", int'(act_vec(1)), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle after reset dut1", int'(act_vec(0)), 0);

    for (int i = 0; i < 17; i++) begin
      run_frame(tbl[i].d, tbl[i].up, tbl[i].dn, tbl[i].retick, tbl[i].rst_at, tbl[i].kind);
      check($sformatf("row%0d shadow_y", i), shadow(tbl[i].d), tbl[i].y);
    end

    // Walk the every-frame instance from 0 down to the lower bound, then push past it.
    for (int i = 0; i < 116; i++) run_frame(0, 1'b0, 1'b1, 0, 0, 1);
    check("shadow_y at bound", shadow(0), 116);
    run_frame(0, 1'b0, 1'b1, 0, 0, 0);
    check("shadow_y held at bound", shadow(0), 116);
    run_frame(0, 1'b1, 1'b0, 0, 0, 2);
    check("shadow_y up from bound", shadow(0), 115);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
